candy_fetch_queue: RTL

Parametrised instruction-fetch unit with prefetch queue; successor to the single-word fetch stage. Owns the fetch PC, issues sequential SRAM reads with one outstanding request, buffers returned words with their addresses in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. Supports PC redirect with queue flush and discard of a stale in-flight read. Sits between the SRAM arbiter and the decode stage.

---
 rtl/candy_fetch_if.sv | 33 +++
 rtl/candy_fetch_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/candy_fetch_if.sv
// Fetch-unit bus bundle: SRAM read port, decode handshake and redirect/fetch control.
// The fetch unit connects through the slave modport; its environment uses master.
interface candy_fetch_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_en;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              sram_read_enable;
    logic [ADDR_W-1:0] sram_addr;
    logic              is_mem;
    logic              data_ready;
    logic [DATA_W-1:0] sram_data;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  fetch_en, redirect, redirect_pc, data_ready, sram_data, inst_ready,
        output sram_read_enable, sram_addr, is_mem, inst_valid, inst, inst_pc, count
    );

    modport master (
        output fetch_en, redirect, redirect_pc, data_ready, sram_data, inst_ready,
        input  sram_read_enable, sram_addr, is_mem, inst_valid, inst, inst_pc, count
    );
endinterface

// File: rtl/candy_fetch_queue.sv
// Instruction fetch with one outstanding SRAM read and a DEPTH-entry prefetch queue
// of {word, address}; redirect flushes the queue and drops any stale in-flight word.
module candy_fetch_queue #(
    parameter int                ADDR_W   = 17,
    parameter int                DATA_W   = 24,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    candy_fetch_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_W+ADDR_W-1:0]   slot_q [DEPTH];
    logic                       head_valid;
    logic                       push;
    logic                       pop;
    logic                       issue_ok;
    logic [ADDR_W-1:0]          seq_pc;

    assign head_valid = (count_q != '0);
    assign push       = (state_q == REQ) && bus.data_ready && !bus.redirect;
    assign pop        = head_valid && bus.inst_ready && !bus.redirect;
    assign seq_pc     = addr_q + ADDR_W'(1);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Occupancy after this edge must leave room for the word a new read will return.
    assign issue_ok = bus.fetch_en && (count_d < CNT_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end else if (issue_ok) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                    if (!bus.data_ready) begin
                        state_d = DISCARD;
                    end else if (bus.fetch_en) begin
                        addr_d = bus.redirect_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.data_ready) begin
                    pc_d = seq_pc;
                    if (issue_ok) addr_d = seq_pc;
                    else          state_d = IDLE;
                end
            end
            DISCARD: begin
                if (bus.redirect) pc_d = bus.redirect_pc;
                if (bus.data_ready) begin
                    if (issue_ok) begin
                        state_d = REQ;
                        addr_d  = pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                slot_q[gi] <= '0;
            else if (push && (wr_ptr_q == PTR_W'(gi)))
                slot_q[gi] <= {bus.sram_data, addr_q};
        end
    end

    assign bus.sram_read_enable = (state_q != IDLE);
    assign bus.is_mem           = (state_q != IDLE);
    assign bus.sram_addr        = addr_q;
    assign bus.inst_valid       = head_valid;
    assign {bus.inst, bus.inst_pc} = slot_q[rd_ptr_q];
    assign bus.count            = count_q;
endmodule
